ram_ctrl: RTL and testbench



---
 rtl/ram_ctrl_pkg.sv | 10 +
 rtl/ram_ctrl.sv | 115 +++++++++++
 tb/tb_ram_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM front-end controller.
// Holds the controller state encoding used by ram_ctrl.
package ram_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ram_ctrl.sv
// CPU-facing controller in front of the single-write-port / async-read RAM.
// Zero-fills memory after reset, arbitrates same-address read/write, registers read data.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH      = 8,
    parameter int WORD_SIZE      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_addr,
    input  logic [MEM_WIDTH-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [WORD_SIZE-1:0] rd_addr,
    output logic                 rd_resp_valid,
    output logic [MEM_WIDTH-1:0] rd_resp_data,
    output logic                 init_done,
    output logic                 ram_wr_en,
    output logic [WORD_SIZE-1:0] ram_wr_addr,
    output logic [WORD_SIZE-1:0] ram_rd_addr,
    output logic [MEM_WIDTH-1:0] ram_data_in,
    input  logic [MEM_WIDTH-1:0] ram_data_out
);

    localparam int                  DEPTH       = 2 ** WORD_SIZE;
    localparam logic [WORD_SIZE:0]  CLR_LAST    = (WORD_SIZE + 1)'(DEPTH - 1);
    localparam logic [WORD_SIZE:0]  CLR_STEP    = (WORD_SIZE + 1)'(1);
    localparam ctrl_state_e         RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    ctrl_state_e          state, state_nxt;
    logic [WORD_SIZE:0]   clr_cnt, clr_cnt_nxt;
    logic                 rd_pri, rd_pri_nxt;
    logic                 conflict;
    logic                 wr_acc;
    logic                 rd_acc;

    assign ram_rd_addr = rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_STATE;
            clr_cnt       <= '0;
            rd_pri        <= 1'b0;
            init_done     <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            state         <= state_nxt;
            clr_cnt       <= clr_cnt_nxt;
            rd_pri        <= rd_pri_nxt;
            init_done     <= (state_nxt == ST_RUN);
            rd_resp_valid <= rd_acc;
            if (rd_acc) begin
                rd_resp_data <= ram_data_out;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rd_pri_nxt  = 1'b0;
        conflict    = 1'b0;
        wr_ready    = 1'b0;
        rd_ready    = 1'b0;
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_data_in = '0;

        case (state)
            ST_CLEAR: begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = clr_cnt[WORD_SIZE-1:0];
                clr_cnt_nxt = clr_cnt + CLR_STEP;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                conflict    = wr_valid && rd_valid && (wr_addr == rd_addr);
                // rd_pri alternates the winner across back-to-back conflicts
                wr_ready    = !(conflict && rd_pri);
                rd_ready    = !(conflict && !rd_pri);
                wr_acc      = wr_valid && wr_ready;
                rd_acc      = rd_valid && rd_ready;
                ram_wr_en   = wr_acc;
                ram_wr_addr = wr_addr;
                ram_data_in = wr_data;
                rd_pri_nxt  = conflict ? !rd_pri : 1'b0;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase

        // Flops already hold reset values; this also silences the combinational
        // outputs (RUN decode when CLEAR_ON_RESET=0, CLEAR write strobe otherwise).
        if (!rst_n) begin
            wr_ready    = 1'b0;
            rd_ready    = 1'b0;
            wr_acc      = 1'b0;
            rd_acc      = 1'b0;
            ram_wr_en   = 1'b0;
            ram_wr_addr = '0;
            ram_data_in = '0;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: behavioural RAM, spec-level reference model,
// per-cycle compare process plus directed scenarios with literal expectations.
module tb_ram_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [3:0] rd_addr;

    logic       wr_ready, rd_ready, rd_resp_valid, init_done, ram_wr_en;
    logic [7:0] rd_resp_data, ram_data_in, ram_data_out;
    logic [3:0] ram_wr_addr, ram_rd_addr;

    logic       wr_ready0, rd_ready0, rd_resp_valid0, init_done0, ram_wr_en0;
    logic [7:0] rd_resp_data0, ram_data_in0;
    logic [3:0] ram_wr_addr0, ram_rd_addr0;

    int n_tests = 0;
    int n_fail  = 0;

    ram_ctrl #(.MEM_WIDTH(8), .WORD_SIZE(4), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .init_done(init_done),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    ram_ctrl #(.MEM_WIDTH(8), .WORD_SIZE(4), .CLEAR_ON_RESET(0)) u_dut_noclr (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(1'b0), .wr_ready(wr_ready0), .wr_addr(4'h0), .wr_data(8'h00),
        .rd_valid(1'b0), .rd_ready(rd_ready0), .rd_addr(4'h0),
        .rd_resp_valid(rd_resp_valid0), .rd_resp_data(rd_resp_data0),
        .init_done(init_done0),
        .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0), .ram_rd_addr(ram_rd_addr0),
        .ram_data_in(ram_data_in0), .ram_data_out(8'h00)
    );

    // Behavioural RAM: synchronous write, combinational read
    logic [7:0] ram_mem [16];
    always @(posedge clk) if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data_in;
    assign ram_data_out = ram_mem[ram_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int         m_clear_left = 16;
    bit         m_done       = 1'b0;
    bit         m_done0      = 1'b0;
    bit         m_pri        = 1'b0;
    bit         m_resp_v     = 1'b0;
    logic [7:0] m_resp_d     = 8'h00;
    logic [7:0] m_mem [16];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_wr_ready",   32'(wr_ready), 0);
            check("rst_rd_ready",   32'(rd_ready), 0);
            check("rst_ram_wr_en",  32'(ram_wr_en), 0);
            check("rst_ram_wr_addr",32'(ram_wr_addr), 0);
            check("rst_ram_data_in",32'(ram_data_in), 0);
            check("rst_init_done",  32'(init_done), 0);
            check("rst_resp_valid", 32'(rd_resp_valid), 0);
            check("rst_resp_data",  32'(rd_resp_data), 0);
            check("rst_noclr_init", 32'(init_done0), 0);
            check("rst_noclr_rdy",  32'({wr_ready0, rd_ready0}), 0);
            m_clear_left = 16;
            m_done   = 1'b0;
            m_done0  = 1'b0;
            m_pri    = 1'b0;
            m_resp_v = 1'b0;
            m_resp_d = 8'h00;
        end else begin
            check("ram_rd_addr",   32'(ram_rd_addr), 32'(rd_addr));
            check("init_done",     32'(init_done), 32'(m_done));
            check("resp_valid",    32'(rd_resp_valid), 32'(m_resp_v));
            check("resp_data",     32'(rd_resp_data), 32'(m_resp_d));
            check("noclr_init",    32'(init_done0), 32'(m_done0));
            check("noclr_rdy",     32'({wr_ready0, rd_ready0}), 3);
            check("noclr_wr_en",   32'(ram_wr_en0), 0);
            m_done0 = 1'b1;
            if (m_clear_left > 0) begin
                int idx;
                idx = 16 - m_clear_left;
                check("clr_wr_ready",  32'(wr_ready), 0);
                check("clr_rd_ready",  32'(rd_ready), 0);
                check("clr_wr_en",     32'(ram_wr_en), 1);
                check("clr_wr_addr",   32'(ram_wr_addr), 32'(idx));
                check("clr_data_in",   32'(ram_data_in), 0);
                m_mem[idx] = 8'h00;
                m_clear_left--;
                if (m_clear_left == 0) m_done = 1'b1;
                m_resp_v = 1'b0;
                m_pri    = 1'b0;
            end else begin
                bit conf, e_wr, e_rd, wen;
                conf = wr_valid && rd_valid && (wr_addr == rd_addr);
                e_wr = !(conf && m_pri);
                e_rd = !(conf && !m_pri);
                wen  = wr_valid && e_wr;
                check("wr_ready",   32'(wr_ready), 32'(e_wr));
                check("rd_ready",   32'(rd_ready), 32'(e_rd));
                check("ram_wr_en",  32'(ram_wr_en), 32'(wen));
                if (wen) begin
                    check("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_addr));
                    check("ram_data_in", 32'(ram_data_in), 32'(wr_data));
                end
                if (rd_valid && e_rd) begin
                    m_resp_v = 1'b1;
                    m_resp_d = m_mem[rd_addr];
                end else begin
                    m_resp_v = 1'b0;
                end
                if (wen) m_mem[wr_addr] = wr_data;
                m_pri = conf ? !m_pri : 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit wv, logic [3:0] wa, logic [7:0] wd, bit rv, logic [3:0] ra);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (init_done) break;
            if (ram_wr_en && n == 0) check("clear_first_addr", 32'(ram_wr_addr), 0);
            if (ram_wr_en) n++;
        end
        check("clear_len", 32'(n), 16);
        check("init_done_after_clear", 32'(init_done), 1);
        check("readys_after_clear", 32'({wr_ready, rd_ready}), 3);
        step();
    endtask

    task automatic check_mem();
        for (int a = 0; a < 16; a++) check("mem_content", 32'(ram_mem[a]), 32'(m_mem[a]));
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        repeat (3) step();
        rst_n = 1'b1;
        count_clear();

        // write then read back
        set_req(1, 4'h3, 8'hA5, 0, 4'h0);
        step();
        set_req(0, 4'h0, 8'h00, 1, 4'h3);
        @(negedge clk); check("t2_rd_ready", 32'(rd_ready), 1);
        step();
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        @(negedge clk);
        check("t2_resp_valid", 32'(rd_resp_valid), 1);
        check("t2_resp_data",  32'(rd_resp_data), 32'h A5);
        step();
        @(negedge clk); check("t2_resp_pulse_end", 32'(rd_resp_valid), 0);
        step();

        // write and read at different addresses in the same cycle
        set_req(1, 4'h6, 8'h66, 0, 4'h0);
        step();
        set_req(1, 4'h5, 8'h3C, 1, 4'h6);
        @(negedge clk); check("t3_both_ready", 32'({wr_ready, rd_ready}), 3);
        step();
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        @(negedge clk); check("t3_resp_data", 32'(rd_resp_data), 32'h66);
        step();

        // conflict with write priority
        set_req(1, 4'h7, 8'h11, 1, 4'h7);
        @(negedge clk); check("t4_conf_ready", 32'({wr_ready, rd_ready}), 2);
        step();
        set_req(0, 4'h0, 8'h00, 1, 4'h7);
        @(negedge clk); check("t4_rd_ready", 32'(rd_ready), 1);
        step();
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        @(negedge clk); check("t4_resp_data", 32'(rd_resp_data), 32'h11);
        step();

        // continuous writes cannot starve a read
        set_req(1, 4'h7, 8'h22, 1, 4'h7);
        @(negedge clk); check("t5_first_ready", 32'({wr_ready, rd_ready}), 2);
        step();
        set_req(1, 4'h7, 8'h33, 1, 4'h7);
        @(negedge clk); check("t5_second_ready", 32'({wr_ready, rd_ready}), 1);
        step();
        set_req(1, 4'h7, 8'h33, 0, 4'h0);
        @(negedge clk);
        check("t5_resp_data", 32'(rd_resp_data), 32'h22);
        check("t5_wr_resume", 32'(wr_ready), 1);
        step();
        set_req(0, 4'h0, 8'h00, 1, 4'h7);
        step();
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        @(negedge clk); check("t5_final_data", 32'(rd_resp_data), 32'h33);
        step();
        check_mem();
        check("t5_mem7", 32'(ram_mem[7]), 32'h33);

        // reset with a response pending drops it
        set_req(0, 4'h0, 8'h00, 1, 4'h3);
        step();
        check("t6_resp_before_rst", 32'(rd_resp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t6_resp_dropped", 32'(rd_resp_valid), 0);
        check("t6_resp_data_rst", 32'(rd_resp_data), 0);
        check("t6_readys_rst", 32'({wr_ready, rd_ready}), 0);
        set_req(0, 4'h0, 8'h00, 0, 4'h0);
        step(); step();
        rst_n = 1'b1;
        repeat (9) step();
        check("t6_clear_at_9", 32'(ram_wr_addr), 9);
        rst_n = 1'b0;
        #1;
        check("t6_midclr_wr_en", 32'(ram_wr_en), 0);
        check("t6_midclr_addr", 32'(ram_wr_addr), 0);
        check("t6_midclr_init", 32'(init_done), 0);
        step(); step();
        rst_n = 1'b1;
        count_clear();
        check_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
